// File: rtl/mul_gate_arbiter.sv
// Round-robin arbiter sharing one mulGate among NREQ requesters; grant -> result in HOLD_CYC cycles.
// Define MUL_GATE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module mul_gate_arbiter #(
    parameter int NREQ     = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_sel,
    input  logic [NREQ-1:0]      req_a,
    input  logic [NREQ-1:0]      req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic                 rsp_z,
    output logic                 busy,
    output logic [1:0]           gate_sel,
    output logic                 gate_a,
    output logic                 gate_b,
    input  logic                 gate_z
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, RESP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [IW-1:0]      owner_q;
    logic [NREQ-1:0]    gnt_q, rsp_valid_q;
    logic               rsp_z_q;
    logic [1:0]         gate_sel_q;
    logic               gate_a_q, gate_b_q;
    logic [IW-1:0]      win;

    function automatic logic [IW-1:0] lowest(input logic [NREQ-1:0] v);
        lowest = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) lowest = IW'(i);
        end
    endfunction

`ifdef MUL_GATE_ARB_FIXED_PRIO_EN
    assign win = lowest(req);
`else
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   ptr_nxt;
    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] req_hi;

    // Requests at or above the pointer take precedence; otherwise wrap to the lowest.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_mask[i] = (IW'(i) >= ptr_q);
        end
        req_hi  = req & hi_mask;
        win     = (|req_hi) ? lowest(req_hi) : lowest(req);
        ptr_nxt = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req)          state_d = APPLY;
            APPLY:   if (cnt_q == '0)   state_d = RESP;
            RESP:                       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_z_q     <= 1'b0;
            gate_sel_q  <= 2'b00;
            gate_a_q    <= 1'b0;
            gate_b_q    <= 1'b0;
            cnt_q       <= '0;
            owner_q     <= '0;
`ifndef MUL_GATE_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q      <= NREQ'(1) << win;
                        gate_sel_q <= req_sel[{win, 1'b0} +: 2];
                        gate_a_q   <= req_a[win];
                        gate_b_q   <= req_b[win];
                        cnt_q      <= CW'(HOLD_CYC - 1);
                        owner_q    <= win;
`ifndef MUL_GATE_ARB_FIXED_PRIO_EN
                        ptr_q      <= ptr_nxt;
`endif
                    end
                end
                APPLY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rsp_z_q     <= gate_z;
                        rsp_valid_q <= NREQ'(1) << owner_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        gnt       = gnt_q;
        rsp_valid = rsp_valid_q;
        rsp_z     = rsp_z_q;
        gate_sel  = gate_sel_q;
        gate_a    = gate_a_q;
        gate_b    = gate_b_q;
    end

endmodule
